// File: rtl/mole_link_pkg.sv
// Shared definitions for the FPGA -> Arduino whack-a-mole command link.
// MOLE_LINK_PARITY_EN adds the parity state to the transmitter state enum.
package mole_link_pkg;

    localparam int PAYLOAD_W = 6;

    typedef enum logic [1:0] {
        CMD_CLEAR     = 2'b00,
        CMD_SHOW      = 2'b01,
        CMD_HIT_OK    = 2'b10,
        CMD_GAME_OVER = 2'b11
    } mole_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_ACK
`ifdef MOLE_LINK_PARITY_EN
        ,
        ST_PARITY
`endif
    } tx_state_t;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [PAYLOAD_W-1:0] payload);
        return ^payload;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inbound Arduino wires.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/mole_link_tx.sv
// Serial command transmitter to the Arduino box controller with ack/timeout/retry.
// Define MOLE_LINK_PARITY_EN to append an even-parity bit before the stop bit.
module mole_link_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ACK_TIMEOUT  = 1024,
    parameter int MAX_RETRY    = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       iLoad,
    input  logic [1:0] iCmd,
    input  logic [3:0] iBox,
    output logic       oReady,
    output logic       oDone,
    output logic       oError,
    output logic       oTx,
    input  logic       iAck
);

    import mole_link_pkg::*;

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int WW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int BW = $clog2(PAYLOAD_W);

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [BW-1:0] BIT_LAST  = BW'(PAYLOAD_W - 1);

    tx_state_t              state_q, state_d;
    logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]          bit_idx_q, bit_idx_d;
    logic [WW-1:0]          wait_cnt_q, wait_cnt_d;
    logic [RW-1:0]          retry_q, retry_d;
    logic [PAYLOAD_W-1:0]   payload_q, payload_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic                   ack_sync;
    logic                   ack_prev_q;
    logic                   ack_edge;
    logic                   bit_end;

    sync_2ff #(.WIDTH(1)) u_ack_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (iAck),
        .q      (ack_sync)
    );

    assign ack_edge = ack_sync & ~ack_prev_q;
    assign bit_end  = (clk_cnt_q == CLK_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            wait_cnt_q <= '0;
            retry_q    <= '0;
            payload_q  <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            ack_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            wait_cnt_q <= wait_cnt_d;
            retry_q    <= retry_d;
            payload_q  <= payload_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            error_q    <= error_d;
            ack_prev_q <= ack_sync;
        end
    end

    // The line value is computed one cycle ahead so oTx comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        wait_cnt_d = wait_cnt_q;
        retry_d    = retry_q;
        payload_d  = payload_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        error_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (iLoad) begin
                    payload_d = {iCmd, iBox};
                    retry_d   = '0;
                    clk_cnt_d = '0;
                    tx_d      = 1'b0;
                    state_d   = ST_START;
                end
            end

            ST_START: begin
                clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
                if (bit_end) begin
                    bit_idx_d = '0;
                    tx_d      = payload_q[0];
                    state_d   = ST_DATA;
                end
            end

            ST_DATA: begin
                clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
                if (bit_end) begin
                    if (bit_idx_q == BIT_LAST) begin
`ifdef MOLE_LINK_PARITY_EN
                        tx_d    = even_parity(payload_q);
                        state_d = ST_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                        tx_d      = payload_q[bit_idx_q + BW'(1)];
                    end
                end
            end

`ifdef MOLE_LINK_PARITY_EN
            ST_PARITY: begin
                clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
            end
`endif

            ST_STOP: begin
                clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
                if (bit_end) begin
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT_ACK;
                end
            end

            // An ack edge outranks a timeout landing in the same cycle.
            ST_WAIT_ACK: begin
                tx_d = 1'b1;
                if (ack_edge) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d   = retry_q + RW'(1);
                        clk_cnt_d = '0;
                        tx_d      = 1'b0;
                        state_d   = ST_START;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign oReady = (state_q == ST_IDLE);
    assign oDone  = done_q;
    assign oError = error_q;
    assign oTx    = tx_q;

endmodule
